// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller (4-word lines).
// Optional hit/miss counters are included when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_W = 2,
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_wr,
  input  logic [9:0]   cpu_addr,
  input  logic [31:0]  cpu_wr_data,
  output logic         cpu_ready,
  output logic         cpu_rd_valid,
  output logic [31:0]  cpu_rd_data,
  output logic         cpu_wr_done,
  output logic         r_mem_req_out,
  output logic         w_mem_req_out,
  output logic [7:0]   mem_addr_out,
  output logic [1:0]   mem_word_id_out,
  output logic [31:0]  mem_wr_data_out,
`ifdef DCACHE_STATS_EN
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt,
`endif
  input  logic         mem_comp_in,
  input  logic [127:0] mem_data_in
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 8 - INDEX_W;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef struct packed {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESP
  } state_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] rd_data_q;

  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [3:0][31:0]       data_q [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word;
  logic               hit, mem_done, fill_we, st_we;
  logic [31:0]        sel_word;

  assign idx      = req_q.addr[2 +: INDEX_W];
  assign tag      = req_q.addr[9 -: TAG_W];
  assign word     = req_q.addr[1:0];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign sel_word = data_q[idx][word];
  // Counter runs out first; a late completion is then taken whenever it arrives.
  assign mem_done = (cnt_q <= CNT_W'(1)) && mem_comp_in;
  assign fill_we  = (state_q == FILL_WAIT) && mem_done;
  assign st_we    = (state_q == LOOKUP) && req_q.wr && hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req_valid)
        req_q <= '{wr: cpu_req_wr, addr: cpu_addr, data: cpu_wr_data};
      if (state_q == FILL_REQ || state_q == WR_REQ)
        cnt_q <= CNT_W'(MEM_LAT);
      else if ((state_q == FILL_WAIT || state_q == WR_WAIT) && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == RESP && !req_q.wr)
        rd_data_q <= sel_word;
      if (fill_we)
        valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= mem_data_in;
      tag_q[idx]  <= tag;
    end else if (st_we) begin
      data_q[idx][word] <= req_q.data;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

  assign cpu_rd_data = (state_q == RESP && !req_q.wr) ? sel_word : rd_data_q;

  always_comb begin
    state_d         = state_q;
    cpu_ready       = 1'b0;
    cpu_rd_valid    = 1'b0;
    cpu_wr_done     = 1'b0;
    r_mem_req_out   = 1'b0;
    w_mem_req_out   = 1'b0;
    mem_addr_out    = '0;
    mem_word_id_out = '0;
    mem_wr_data_out = '0;
    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (req_q.wr)  state_d = WR_REQ;
        else if (hit)  state_d = RESP;
        else           state_d = FILL_REQ;
      end
      FILL_REQ: begin
        r_mem_req_out = 1'b1;
        mem_addr_out  = req_q.addr[9:2];
        state_d       = FILL_WAIT;
      end
      FILL_WAIT: begin
        mem_addr_out = req_q.addr[9:2];
        if (mem_done) state_d = RESP;
      end
      WR_REQ: begin
        w_mem_req_out   = 1'b1;
        mem_addr_out    = req_q.addr[9:2];
        mem_word_id_out = word;
        mem_wr_data_out = req_q.data;
        state_d         = WR_WAIT;
      end
      WR_WAIT: begin
        mem_addr_out    = req_q.addr[9:2];
        mem_word_id_out = word;
        mem_wr_data_out = req_q.data;
        if (mem_done) state_d = RESP;
      end
      // Shared completion cycle: stores pulse wr_done, loads pulse rd_valid.
      RESP: begin
        if (req_q.wr) cpu_wr_done  = 1'b1;
        else          cpu_rd_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Table-driven bench for dcache_ctrl with a line-wide memory model whose completion can be delayed.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         cpu_req_valid, cpu_req_wr;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wr_data;
  logic         cpu_ready, cpu_rd_valid, cpu_wr_done;
  logic [31:0]  cpu_rd_data;
  logic         r_mem_req_out, w_mem_req_out;
  logic [7:0]   mem_addr_out;
  logic [1:0]   mem_word_id_out;
  logic [31:0]  mem_wr_data_out;
  logic         mem_comp_in = 1'b0;
  logic [127:0] mem_data_in = '0;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.INDEX_W(2), .MEM_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_wr(cpu_req_wr),
    .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_ready(cpu_ready), .cpu_rd_valid(cpu_rd_valid),
    .cpu_rd_data(cpu_rd_data), .cpu_wr_done(cpu_wr_done),
    .r_mem_req_out(r_mem_req_out), .w_mem_req_out(w_mem_req_out),
    .mem_addr_out(mem_addr_out), .mem_word_id_out(mem_word_id_out),
    .mem_wr_data_out(mem_wr_data_out),
`ifdef DCACHE_STATS_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_comp_in(mem_comp_in), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  // Memory: line L word w holds {L, w} except line 0x25 = 1111/2222/3333/4444.
  logic [127:0] mem [256];
  bit  init_done = 1'b0;
  int  comp_delay = 0;
  int  dcnt = 0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int l = 0; l < 256; l++)
        for (int w = 0; w < 4; w++)
          mem[l][w*32 +: 32] <= {l[15:0], w[15:0]};
      mem[8'h25] <= {32'h4444, 32'h3333, 32'h2222, 32'h1111};
      init_done <= 1'b1;
    end else if (r_mem_req_out || w_mem_req_out) begin
      if (r_mem_req_out) mem_data_in <= mem[mem_addr_out];
      if (w_mem_req_out) mem[mem_addr_out][mem_word_id_out*32 +: 32] <= mem_wr_data_out;
      if (comp_delay == 0) mem_comp_in <= 1'b1;
      else begin
        mem_comp_in <= 1'b0;
        dcnt <= comp_delay;
      end
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) mem_comp_in <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          delay;
    int          lat;
    int          nrd;
    logic [31:0] rdata;
  } vec_t;

  task automatic run_op(input string nm, input vec_t v);
    int cyc = 0, lat = 0, nr = 0, nw = 0;
    bit done = 0;
    logic [7:0]  a  = '0;
    logic [1:0]  wid = '0;
    logic [31:0] wd = '0, got = '0;
    comp_delay = v.delay;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_wr = v.wr; cpu_addr = v.addr; cpu_wr_data = v.wdata;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (r_mem_req_out) begin nr++; a = mem_addr_out; end
      if (w_mem_req_out) begin nw++; a = mem_addr_out; wid = mem_word_id_out; wd = mem_wr_data_out; end
      if (!v.wr && cpu_rd_valid) begin done = 1; lat = cyc; got = cpu_rd_data; end
      if (v.wr && cpu_wr_done) begin done = 1; lat = cyc; end
    end
    chk({nm, " completes"}, 64'(done), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(v.lat));
    chk({nm, " line reads"}, 64'(nr), 64'(v.nrd));
    chk({nm, " word writes"}, 64'(nw), v.wr ? 64'd1 : 64'd0);
    if (v.wr) begin
      chk({nm, " wr addr"}, 64'(a), 64'(v.addr[9:2]));
      chk({nm, " wr word"}, 64'(wid), 64'(v.addr[1:0]));
      chk({nm, " wr data"}, 64'(wd), 64'(v.wdata));
    end else begin
      chk({nm, " rd data"}, 64'(got), 64'(v.rdata));
      if (v.nrd != 0) chk({nm, " fill addr"}, 64'(a), 64'(v.addr[9:2]));
    end
    @(negedge clk);
    chk({nm, " back idle"}, {61'd0, cpu_ready, cpu_rd_valid, cpu_wr_done}, 64'b100);
    if (!v.wr) chk({nm, " rd data held"}, 64'(cpu_rd_data), 64'(v.rdata));
  endtask

  vec_t tbl [14];
  int   rv;

  initial begin
    //        wr  addr    wdata          dly lat nrd rdata
    tbl[0]  = '{0, 10'h096, 32'h0,         0, 4, 1, 32'h0000_3333};
    tbl[1]  = '{0, 10'h094, 32'h0,         0, 2, 0, 32'h0000_1111};
    tbl[2]  = '{1, 10'h097, 32'hDEAD_BEEF, 0, 4, 0, 32'h0};
    tbl[3]  = '{0, 10'h097, 32'h0,         0, 2, 0, 32'hDEAD_BEEF};
    tbl[4]  = '{1, 10'h3F0, 32'h1234_5678, 0, 4, 0, 32'h0};
    tbl[5]  = '{0, 10'h3F0, 32'h0,         0, 4, 1, 32'h1234_5678};
    tbl[6]  = '{0, 10'h1D6, 32'h0,         0, 4, 1, 32'h0075_0002};
    tbl[7]  = '{0, 10'h096, 32'h0,         0, 4, 1, 32'h0000_3333};
    tbl[8]  = '{0, 10'h3F1, 32'h0,         0, 2, 0, 32'h00FC_0001};
    tbl[9]  = '{1, 10'h3F2, 32'hCAFE_F00D, 0, 4, 0, 32'h0};
    tbl[10] = '{0, 10'h3F2, 32'h0,         0, 2, 0, 32'hCAFE_F00D};
    tbl[11] = '{0, 10'h0E4, 32'h0,         3, 7, 1, 32'h0039_0000};
    tbl[12] = '{1, 10'h0E5, 32'h1111_2222, 2, 6, 0, 32'h0};
    tbl[13] = '{0, 10'h0E5, 32'h0,         0, 2, 0, 32'h1111_2222};

    reset_n = 1'b0; cpu_req_valid = 1'b0; cpu_req_wr = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    #2;
    chk("reset ready", 64'(cpu_ready), 64'd1);
    chk("reset pulses", {60'd0, cpu_rd_valid, cpu_wr_done, r_mem_req_out, w_mem_req_out}, 64'd0);
    chk("reset mem outs", {22'd0, mem_addr_out, mem_word_id_out, mem_wr_data_out}, 64'd0);
    chk("reset rd data", 64'(cpu_rd_data), 64'd0);
`ifdef DCACHE_STATS_EN
    chk("reset stats", {32'd0, hit_cnt, miss_cnt}, 64'd0);
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i]);
`ifdef DCACHE_STATS_EN
      if (i == 1) chk("stats after vec1", {32'd0, hit_cnt, miss_cnt}, {32'd0, 16'd1, 16'd1});
`endif
    end
`ifdef DCACHE_STATS_EN
    chk("stats after table", {32'd0, hit_cnt, miss_cnt}, {32'd0, 16'd8, 16'd6});
`endif

    // Reset while a fill is waiting on a slow memory.
    comp_delay = 5;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_wr = 1'b0; cpu_addr = 10'h0A8;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort fill req", {55'd0, r_mem_req_out, mem_addr_out}, {55'd0, 1'b1, 8'h2A});
    @(negedge clk);
    chk("abort in wait", {55'd0, r_mem_req_out, mem_addr_out}, {55'd0, 1'b0, 8'h2A});
    reset_n = 1'b0;
    #1;
    chk("abort ready", 64'(cpu_ready), 64'd1);
    chk("abort outs", {23'd0, cpu_rd_valid, r_mem_req_out, mem_addr_out, cpu_rd_data}, 64'd0);
`ifdef DCACHE_STATS_EN
    chk("abort stats", {32'd0, hit_cnt, miss_cnt}, 64'd0);
`endif
    rv = 0;
    repeat (2) begin @(negedge clk); if (cpu_rd_valid) rv++; end
    reset_n = 1'b1;
    repeat (8) begin @(negedge clk); if (cpu_rd_valid || !cpu_ready) rv++; end
    chk("abort no pulse", 64'(rv), 64'd0);

    run_op("post-reset 0A8", '{0, 10'h0A8, 32'h0, 0, 4, 1, 32'h002A_0000});
    run_op("post-reset 094", '{0, 10'h094, 32'h0, 0, 4, 1, 32'h0000_1111});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
